// File: rtl/decode_pipe.sv
// decode_pipe: single-stage instruction decode with register file and scoreboard.
//
// Decodes a 32-bit RV32-style instruction into operands ra/rb/pass, an instruction
// class (itype) and a destination index. The instruction is accepted when
// ir_valid_i && ir_ready_o. The decoded result is then registered and appears with
// out_valid_o on the next cycle. A per-register pending bit stalls readers of
// registers whose write-back has not yet arrived.
//
// Optional feature: define DECODE_BYPASS_EN to forward same-cycle write-back data
// to the operands instead of stalling for one cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ir_i, ir_valid_i    instruction word and its valid
//   ir_ready_o          decode accepts ir_i this cycle
//   ra_o, rb_o, pass_o  decoded operands
//   itype_o, rd_o       instruction class and destination index
//   out_valid_o         output register holds a decoded instruction
//   out_ready_i         downstream consumes the output this cycle
//   wd_i, wd_addr_i     write-back data and register index
//   wd_q_i              write-back strobe
//   halt_o              sticky exit flag, set by writing 32'hDEAD to x31
//
// itype codes: 0 unknown, 1 R, 2 I, 3 S, 4 B, 5 L, 6 U, 7 JAL, 8 JALR.

module decode_pipe #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] SP_RESET = 'h12000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ir_i,
  input  logic            ir_valid_i,
  output logic            ir_ready_o,
  output logic [XLEN-1:0] ra_o,
  output logic [XLEN-1:0] rb_o,
  output logic [XLEN-1:0] pass_o,
  output logic [4:0]      itype_o,
  output logic [4:0]      rd_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  input  logic [XLEN-1:0] wd_i,
  input  logic [4:0]      wd_addr_i,
  input  logic            wd_q_i,
  output logic            halt_o
);

  localparam logic [4:0] IT_NONE = 5'd0;
  localparam logic [4:0] IT_R    = 5'd1;
  localparam logic [4:0] IT_I    = 5'd2;
  localparam logic [4:0] IT_S    = 5'd3;
  localparam logic [4:0] IT_B    = 5'd4;
  localparam logic [4:0] IT_L    = 5'd5;
  localparam logic [4:0] IT_U    = 5'd6;
  localparam logic [4:0] IT_JAL  = 5'd7;
  localparam logic [4:0] IT_JALR = 5'd8;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_L     = 7'h03;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;

  localparam int unsigned AW     = $clog2(NREG);
  localparam logic [5:0]  NREG_W = 6'(NREG);

  // State
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic            halt_q;
  logic            out_valid_q;
  logic [XLEN-1:0] ra_q, rb_q, pass_q;
  logic [4:0]      itype_q, rd_q;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] imm_i, imm_s;
  logic [12:0] imm_b;
  logic [20:0] imm_j;

  assign opcode = ir_i[6:0];
  assign rd     = ir_i[11:7];
  assign rs1    = ir_i[19:15];
  assign rs2    = ir_i[24:20];
  assign imm_i  = ir_i[31:20];
  assign imm_s  = {ir_i[31:25], ir_i[11:7]};
  assign imm_b  = {ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
  assign imm_j  = {ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};

  // An index is "live" when it names a real, writable register (not x0, below NREG).
  logic rs1_ok, rs2_ok, rd_ok, wd_ok;
  assign rs1_ok = (rs1 != 5'd0) && ({1'b0, rs1} < NREG_W);
  assign rs2_ok = (rs2 != 5'd0) && ({1'b0, rs2} < NREG_W);
  assign rd_ok  = (rd != 5'd0) && ({1'b0, rd} < NREG_W);
  assign wd_ok  = (wd_addr_i != 5'd0) && ({1'b0, wd_addr_i} < NREG_W);

  logic [XLEN-1:0] rs1_rf, rs2_rf, rs1_val, rs2_val;
  logic            pend1, pend2, wb_hit1, wb_hit2, rs1_haz, rs2_haz;

  assign rs1_rf  = rs1_ok ? regs[rs1[AW-1:0]] : '0;
  assign rs2_rf  = rs2_ok ? regs[rs2[AW-1:0]] : '0;
  assign pend1   = rs1_ok && pending_q[rs1[AW-1:0]];
  assign pend2   = rs2_ok && pending_q[rs2[AW-1:0]];
  assign wb_hit1 = wd_q_i && (wd_addr_i == rs1) && rs1_ok;
  assign wb_hit2 = wd_q_i && (wd_addr_i == rs2) && rs2_ok;

`ifdef DECODE_BYPASS_EN
  assign rs1_val = wb_hit1 ? wd_i : rs1_rf;
  assign rs2_val = wb_hit2 ? wd_i : rs2_rf;
  assign rs1_haz = pend1 && !wb_hit1;
  assign rs2_haz = pend2 && !wb_hit2;
`else
  // Same-cycle write-back collides with the read; wait for the register file.
  assign rs1_val = rs1_rf;
  assign rs2_val = rs2_rf;
  assign rs1_haz = pend1 || wb_hit1;
  assign rs2_haz = pend2 || wb_hit2;
`endif

  // Decode
  logic [XLEN-1:0] ra_d, rb_d, pass_d;
  logic [4:0]      itype_d, rd_d;
  logic            use_rs1, use_rs2, wr_rd;

  always_comb begin
    ra_d    = '0;
    rb_d    = '0;
    pass_d  = '0;
    itype_d = IT_NONE;
    rd_d    = 5'd0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    case (opcode)
      OP_R: begin
        itype_d = IT_R;
        ra_d    = rs1_val;
        rb_d    = rs2_val;
        rd_d    = rd;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_rd   = 1'b1;
      end
      OP_I: begin
        itype_d = IT_I;
        ra_d    = rs1_val;
        rb_d    = XLEN'($signed(imm_i));
        rd_d    = rd;
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
      end
      OP_S: begin
        itype_d = IT_S;
        ra_d    = XLEN'($signed(imm_s));
        rb_d    = rs1_val;
        pass_d  = rs2_val;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_B: begin
        itype_d = IT_B;
        ra_d    = rs1_val;
        rb_d    = rs2_val;
        pass_d  = XLEN'($signed(imm_b));
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_L: begin
        itype_d = IT_L;
        ra_d    = XLEN'($signed(imm_i));
        rb_d    = rs1_val;
        rd_d    = rd;
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        itype_d = IT_U;
        ra_d    = XLEN'($signed({ir_i[31:12], 12'b0}));
        rd_d    = rd;
        wr_rd   = 1'b1;
      end
      OP_JAL: begin
        itype_d = IT_JAL;
        ra_d    = XLEN'($signed(imm_j));
        rd_d    = rd;
        wr_rd   = 1'b1;
      end
      OP_JALR: begin
        itype_d = IT_JALR;
        ra_d    = rs1_val;
        rb_d    = XLEN'($signed(imm_i));
        rd_d    = rd;
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
      end
      default: ;
    endcase
  end

  // Handshake
  logic hazard, accept;
  assign hazard     = ir_valid_i && ((use_rs1 && rs1_haz) || (use_rs2 && rs2_haz));
  assign ir_ready_o = !reset && (!out_valid_q || out_ready_i) && !hazard && !halt_q;
  assign accept     = ir_valid_i && ir_ready_o;

  // Scoreboard: a set from a new accept wins over a same-cycle write-back clear.
  always_comb begin
    pending_d = pending_q;
    if (wd_q_i && wd_ok) pending_d[wd_addr_i[AW-1:0]] = 1'b0;
    if (accept && wr_rd && rd_ok) pending_d[rd[AW-1:0]] = 1'b1;
  end

  // Register file, scoreboard and halt flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      halt_q    <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[AW'(i)] <= (i == 32'd2) ? SP_RESET : '0;
      end
    end else begin
      pending_q <= pending_d;
      if (wd_q_i && wd_ok) regs[wd_addr_i[AW-1:0]] <= wd_i;
      if (wd_q_i && (wd_addr_i == 5'd31) && (wd_i == XLEN'(32'hDEAD))) halt_q <= 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ra_q        <= '0;
      rb_q        <= '0;
      pass_q      <= '0;
      itype_q     <= IT_NONE;
      rd_q        <= 5'd0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      pass_q      <= pass_d;
      itype_q     <= itype_d;
      rd_q        <= rd_d;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign ra_o        = ra_q;
  assign rb_o        = rb_q;
  assign pass_o      = pass_q;
  assign itype_o     = itype_q;
  assign rd_o        = rd_q;
  assign halt_o      = halt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed steps, expected outputs queued at
// accept time and compared when the output register presents them.

module tb_decode_pipe;

  localparam logic [4:0] IT_R    = 5'd1;
  localparam logic [4:0] IT_I    = 5'd2;
  localparam logic [4:0] IT_S    = 5'd3;
  localparam logic [4:0] IT_B    = 5'd4;
  localparam logic [4:0] IT_L    = 5'd5;
  localparam logic [4:0] IT_U    = 5'd6;
  localparam logic [4:0] IT_JAL  = 5'd7;
  localparam logic [4:0] IT_JALR = 5'd8;

`ifdef DECODE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir_i = '0;
  logic        ir_valid_i = 1'b0;
  logic        ir_ready_o;
  logic [31:0] ra_o, rb_o, pass_o;
  logic [4:0]  itype_o, rd_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] wd_i = '0;
  logic [4:0]  wd_addr_i = '0;
  logic        wd_q_i = 1'b0;
  logic        halt_o;

  decode_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .ir_i       (ir_i),
    .ir_valid_i (ir_valid_i),
    .ir_ready_o (ir_ready_o),
    .ra_o       (ra_o),
    .rb_o       (rb_o),
    .pass_o     (pass_o),
    .itype_o    (itype_o),
    .rd_o       (rd_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .wd_i       (wd_i),
    .wd_addr_i  (wd_addr_i),
    .wd_q_i     (wd_q_i),
    .halt_o     (halt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] pass;
    logic [4:0]  itype;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ra, input logic [31:0] rb,
                              input logic [31:0] pass, input logic [4:0] it,
                              input logic [4:0] rd);
    exp_t e;
    e.ra = ra; e.rb = rb; e.pass = pass; e.itype = it; e.rd = rd;
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // Pop the oldest expectation and compare it with the presented output.
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'b0, out_valid_o}, 32'd1);
    chk({tag, "_sbdepth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_ra"}, ra_o, e.ra);
      chk({tag, "_rb"}, rb_o, e.rb);
      chk({tag, "_pass"}, pass_o, e.pass);
      chk({tag, "_itype"}, {27'b0, itype_o}, {27'b0, e.itype});
      chk({tag, "_rd"}, {27'b0, rd_o}, {27'b0, e.rd});
    end
  endtask

  // Present an instruction, wait (bounded) for acceptance, check stall count and output.
  task automatic issue(input string tag, input logic [31:0] ir, input exp_t e,
                       input int exp_wait);
    int waited;
    waited = 0;
    ir_i = ir;
    ir_valid_i = 1'b1;
    #1;
    while (!ir_ready_o && waited < 8) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk({tag, "_wait"}, waited, exp_wait);
    if (ir_ready_o) begin
      sb.push_back(e);
      @(negedge clk);
      ir_valid_i = 1'b0;
      check_out(tag);
    end else begin
      ir_valid_i = 1'b0;
    end
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wd_q_i = 1'b1;
    wd_addr_i = addr;
    wd_i = data;
    @(negedge clk);
    wd_q_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    ir_i = enc_r(5'd3, 5'd2, 5'd0);
    ir_valid_i = 1'b1;
    #1;
    chk("rst_ready", {31'b0, ir_ready_o}, 32'd0);
    chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_halt", {31'b0, halt_o}, 32'd0);
    chk("rst_ra", ra_o, 32'd0);
    chk("rst_rb", rb_o, 32'd0);
    chk("rst_pass", pass_o, 32'd0);
    chk("rst_rd", {27'b0, rd_o}, 32'd0);
    chk("rst_itype", {27'b0, itype_o}, 32'd0);
    ir_valid_i = 1'b0;
    reset = 1'b0;

    // add x3,x2,x0 followed by one of each class, back to back
    issue("add3", enc_r(5'd3, 5'd2, 5'd0), mk(32'h12000, 0, 0, IT_R, 5'd3), 0);
    issue("sw", enc_s(5'd2, 5'd2, 12'hFFC),
          mk(32'hFFFF_FFFC, 32'h12000, 32'h12000, IT_S, 5'd0), 0);
    issue("beq", enc_b(5'd2, 5'd0, 13'h1FF8), mk(32'h12000, 0, 32'hFFFF_FFF8, IT_B, 5'd0), 0);
    issue("lw", enc_i(7'h03, 5'd7, 5'd2, 12'h010), mk(32'h10, 32'h12000, 0, IT_L, 5'd7), 0);
    issue("lui", enc_u(5'd8, 20'hABCDE), mk(32'hABCD_E000, 0, 0, IT_U, 5'd8), 0);
    issue("jal", enc_j(5'd1, 21'h1FF004), mk(32'hFFFF_F004, 0, 0, IT_JAL, 5'd1), 0);
    issue("jalr", enc_i(7'h67, 5'd9, 5'd2, 12'h004), mk(32'h12000, 32'h4, 0, IT_JALR, 5'd9), 0);
    // Unknown opcode with rd field 11 must not mark x11 pending
    issue("unknown", 32'hFFFF_F5FF, mk(0, 0, 0, 5'd0, 5'd0), 0);
    issue("add12", enc_r(5'd12, 5'd11, 5'd0), mk(0, 0, 0, IT_R, 5'd12), 0);

    // Drain, then addi x5,x0,-1 held by a stalled consumer for 3 cycles
    @(negedge clk);
    chk("drain_valid", {31'b0, out_valid_o}, 32'd0);
    out_ready_i = 1'b0;
    issue("addi5", enc_i(7'h13, 5'd5, 5'd0, 12'hFFF), mk(0, 32'hFFFF_FFFF, 0, IT_I, 5'd5), 0);
    ir_i = enc_u(5'd8, 20'h12345);
    ir_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("hold_ready", {31'b0, ir_ready_o}, 32'd0);
      chk("hold_valid", {31'b0, out_valid_o}, 32'd1);
      chk("hold_rb", rb_o, 32'hFFFF_FFFF);
      chk("hold_rd", {27'b0, rd_o}, 32'd5);
      chk("hold_itype", {27'b0, itype_o}, {27'b0, IT_I});
    end
    ir_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("release_valid", {31'b0, out_valid_o}, 32'd0);

    // RAW on x5: add x6,x5,x5 stalls until write-back x5=7 two cycles later
    issue("addi5b", enc_i(7'h13, 5'd5, 5'd0, 12'h003), mk(0, 32'h3, 0, IT_I, 5'd5), 0);
    ir_i = enc_r(5'd6, 5'd5, 5'd5);
    ir_valid_i = 1'b1;
    #1;
    chk("raw_stall0", {31'b0, ir_ready_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("raw_stall1", {31'b0, ir_ready_o}, 32'd0);
    @(negedge clk);
    wd_q_i = 1'b1;
    wd_addr_i = 5'd5;
    wd_i = 32'd7;
    #1;
    chk("raw_wb_ready", {31'b0, ir_ready_o}, BYP);
    if (ir_ready_o) sb.push_back(mk(32'd7, 32'd7, 0, IT_R, 5'd6));
    @(negedge clk);
    wd_q_i = 1'b0;
    if (BYP == 0) begin
      #1;
      chk("raw_next_ready", {31'b0, ir_ready_o}, 32'd1);
      if (ir_ready_o) sb.push_back(mk(32'd7, 32'd7, 0, IT_R, 5'd6));
      @(negedge clk);
    end
    ir_valid_i = 1'b0;
    check_out("add6");

    // x0 ignores writes; other registers take them
    wb(5'd0, 32'h55);
    issue("add1_x0", enc_r(5'd1, 5'd0, 5'd0), mk(0, 0, 0, IT_R, 5'd1), 0);
    wb(5'd4, 32'h1234);
    wb(5'd2, 32'h999);
    issue("add10", enc_r(5'd10, 5'd4, 5'd2), mk(32'h1234, 32'h999, 0, IT_R, 5'd10), 0);

    // Set beats a same-cycle clear on x13
    wd_q_i = 1'b1;
    wd_addr_i = 5'd13;
    wd_i = 32'h77;
    issue("addi13", enc_i(7'h13, 5'd13, 5'd0, 12'h001), mk(0, 32'h1, 0, IT_I, 5'd13), 0);
    wd_q_i = 1'b0;
    ir_i = enc_r(5'd14, 5'd13, 5'd0);
    ir_valid_i = 1'b1;
    repeat (2) begin
      #1;
      chk("setwin_stall", {31'b0, ir_ready_o}, 32'd0);
      @(negedge clk);
    end
    ir_valid_i = 1'b0;
    wb(5'd13, 32'h42);
    issue("add14", enc_r(5'd14, 5'd13, 5'd0), mk(32'h42, 0, 0, IT_R, 5'd14), 0);

    // Halt on x31 <= DEAD, sticky until reset
    wb(5'd31, 32'hDEAD);
    ir_i = enc_r(5'd3, 5'd2, 5'd0);
    ir_valid_i = 1'b1;
    #1;
    chk("halt_set", {31'b0, halt_o}, 32'd1);
    chk("halt_ready", {31'b0, ir_ready_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("halt_sticky", {31'b0, halt_o}, 32'd1);
    chk("halt_ready2", {31'b0, ir_ready_o}, 32'd0);
    ir_valid_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("halt_clear", {31'b0, halt_o}, 32'd0);
    issue("add3_post", enc_r(5'd3, 5'd2, 5'd0), mk(32'h12000, 0, 0, IT_R, 5'd3), 0);

    // Reset over a held output, pending x5, write-back and accept in the same cycle
    @(negedge clk);
    out_ready_i = 1'b0;
    issue("addi5c", enc_i(7'h13, 5'd5, 5'd0, 12'h00F), mk(0, 32'hF, 0, IT_I, 5'd5), 0);
    reset = 1'b1;
    wd_q_i = 1'b1;
    wd_addr_i = 5'd4;
    wd_i = 32'hBEEF;
    ir_i = enc_i(7'h13, 5'd7, 5'd0, 12'h001);
    ir_valid_i = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wd_q_i = 1'b0;
    ir_valid_i = 1'b0;
    out_ready_i = 1'b1;
    chk("rst2_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst2_rb", rb_o, 32'd0);
    chk("rst2_rd", {27'b0, rd_o}, 32'd0);
    chk("rst2_itype", {27'b0, itype_o}, 32'd0);
    issue("add6_post", enc_r(5'd6, 5'd5, 5'd0), mk(0, 0, 0, IT_R, 5'd6), 0);
    issue("add16", enc_r(5'd16, 5'd4, 5'd0), mk(0, 0, 0, IT_R, 5'd16), 0);
    issue("add17", enc_r(5'd17, 5'd7, 5'd0), mk(0, 0, 0, IT_R, 5'd17), 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL provide parameter NREG, default 32, architectural register count; legal values are 16 or 32, and the index is 5 bits.
REQ-003 SHALL provide parameter SP_RESET, default 'h12000, the reset value of x2.
REQ-004 SHALL provide clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide ir_i  input  32  instruction word.
REQ-007 SHALL provide ir_valid_i  input  1  instruction present.
REQ-008 SHALL provide ir_ready_o  output  1  decode accepts ir_i this cycle.
REQ-009 SHALL provide ra_o, rb_o, pass_o  output  XLEN each  decoded operands.
REQ-010 SHALL provide itype_o  output  5  instruction class, using the itype.v codes.
REQ-011 SHALL provide rd_o  output  5  destination register index.
REQ-012 SHALL provide out_valid_o  output  1  output register holds a decoded instruction.
REQ-013 SHALL provide out_ready_i  input  1  downstream consumes the output this cycle.
REQ-014 SHALL provide wd_i  input  XLEN  write-back data.
REQ-015 SHALL provide wd_addr_i  input  5  write-back register index.
REQ-016 SHALL provide wd_q_i  input  1  write-back strobe, level-sampled at posedge.
REQ-017 SHALL provide halt_o  output  1  sticky simulation-exit flag.

Function
REQ-018 Pipeline: a single output register stage; an instruction is accepted when ir_valid_i && ir_ready_o; results appear on the outputs with out_valid_o=1 on the following cycle.
REQ-019 ir_ready_o SHALL equal (!out_valid_o || out_ready_i) && !hazard && !halt_o.
REQ-020 out_valid_o SHALL clear on out_ready_i when no new accept occurs in the same cycle; while out_valid_o && !out_ready_i, all outputs SHALL hold stable.
REQ-021 Operands per opcode (opcode.v macros):
- R: ra=x[rs1], rb=x[rs2].
- I: ra=x[rs1], rb=sext(ir[31:20]).
- S: ra=sext({ir[31:25],ir[11:7]}), rb=x[rs1], pass=x[rs2].
- B: ra=x[rs1], rb=x[rs2], pass=sext({ir[31],ir[7],ir[30:25],ir[11:8],0}).
- L: ra=sext(ir[31:20]), rb=x[rs1].
- U: ra={ir[31:12],12'b0}.
- JAL: ra=sext J-immediate.
- JALR: ra=x[rs1], rb=sext(ir[31:20]).
- Unused operand fields SHALL be 0.
REQ-022 An unknown opcode SHALL decode as itype 0 with all operands 0, SHALL be accepted, and SHALL set no pending bit.
REQ-023 x0 SHALL read 0; writes to x0 SHALL be ignored; an index >= NREG SHALL read 0 and its writes SHALL be ignored.
REQ-024 Scoreboard: one pending bit per register; on accept of R/I/L/U/JAL/JALR with rd!=0, pending[rd] SHALL be set; on wd_q_i, pending[wd_addr_i] SHALL be cleared.
- If set and clear hit the same index in the same cycle, set SHALL win.
REQ-025 hazard SHALL be 1 when ir_valid_i and any source register actually used by the opcode has its pending bit set, except where REQ-033 applies.
REQ-026 A write-back SHALL update the register at posedge; a read in the same cycle SHALL return the old value unless REQ-033 applies.
REQ-027 A write-back of 32'hDEAD to x31 SHALL set halt_o on the next cycle; halt_o SHALL stay set until reset, and no further instruction SHALL be accepted.

Reset
REQ-028 On reset, all registers SHALL become 0, x2 SHALL become SP_RESET, and all pending bits SHALL clear.
REQ-029 On reset, out_valid_o, halt_o, ra_o, rb_o, pass_o, rd_o and itype_o SHALL be 0.
REQ-030 An asserted reset SHALL take precedence over write-back and accept in the same cycle; a held output SHALL be discarded.
REQ-031 ir_ready_o SHALL be 0 while reset is asserted.

Configuration
REQ-032 Write-back bypass SHALL be compiled in by macro DECODE_BYPASS_EN.
REQ-033 With DECODE_BYPASS_EN defined: if wd_q_i && wd_addr_i==source!=0 in the accept cycle, that source SHALL not count as a hazard, and wd_i SHALL be forwarded as its operand.
REQ-034 Without DECODE_BYPASS_EN: that case SHALL stall one cycle, and the instruction SHALL be accepted on the next cycle using the register-file value.

Verification
REQ-035 Reset, then issue R-type add x3,x2,x0 -> ra_o='h12000, rb_o=0, itype_o=RTYPE, rd_o=3, out_valid_o=1 one cycle after accept.
REQ-036 Issue addi x5,x0,-1 -> rb_o='hFFFFFFFF; then hold out_ready_i=0 for 3 cycles -> outputs stable and ir_ready_o=0.
REQ-037 Issue addi x5, then add x6,x5,x5 with write-back x5=7 two cycles later -> add stalls until write-back; operands are 7/7 on the write-back cycle (bypass) or the cycle after (no bypass).
REQ-038 Write-back x0='h55, then add x1,x0,x0 -> ra_o=rb_o=0.
REQ-039 Write-back x31=32'hDEAD -> halt_o=1 on the next cycle and ir_ready_o=0; assert reset -> halt_o=0 and x2='h12000.
REQ-040 Assert reset while out_valid_o=1 and pending[5]=1 -> next cycle out_valid_o=0, and add x6,x5,x0 is accepted without stall.
